// File: rtl/spi_pkg.sv
// Shared SPI package: constants for the SPI transmitter and receiver, and the
// receiver FSM state encoding.
package spi_pkg;

    // Default word length, shared by the transmitter and the receiver
    localparam int SPI_LARGO_DEF = 8;

    localparam int SPI_TX_DIV_DEF  = 4;
    localparam bit SPI_TX_CPOL_DEF = 1'b0;
    localparam bit SPI_TX_CPHA_DEF = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    function automatic int cnt_width(input int largo);
        return (largo > 2) ? $clog2(largo) : 1;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for SPI frames: synchronous clear, increment, and a flag that
// marks the last bit position of the word.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int LARGO = SPI_LARGO_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CW = cnt_width(LARGO);
    localparam logic [CW-1:0] LAST = CW'(LARGO - 1);

    logic [CW-1:0] r_count;

    // Returns to zero after the last bit so the count never exceeds LARGO-1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == LAST);

endmodule

// File: rtl/spi_sipo_rx.sv
// SPI serial-in/parallel-out receiver: shifts DatIn on each ena strobe and
// hands completed words to a consumer through a valid/rd_ack holding register.
module spi_sipo_rx
    import spi_pkg::*;
#(
    parameter int LARGO     = SPI_LARGO_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ena,
    input  logic             DatIn,
    input  logic             rd_ack,
    input  logic             clr_ovr,
    output logic [LARGO-1:0] DatOut,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [LARGO-1:0] r_sr;
    logic [LARGO-1:0] w_srShift;
    logic [LARGO-1:0] r_datOut;
    logic             r_valid;
    logic             r_overrun;
    logic             w_sample;
    logic             w_tc;
    logic             w_done;
    logic             w_drop;

    // start has priority over ena, so a strobe in the start cycle is ignored
    assign w_sample = (r_state == RECV) && ena && !start;
    assign w_done   = w_sample && w_tc;
    assign w_drop   = w_done && r_valid && !rd_ack;

    spi_bit_counter #(
        .LARGO (LARGO)
    ) u_bit_counter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (start),
        .i_inc   (w_sample),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_srShift = r_sr;
        if (MSB_FIRST) begin
            w_srShift = {r_sr[LARGO-2:0], DatIn};
        end else begin
            w_srShift = {DatIn, r_sr[LARGO-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = RECV;
        end else if (w_done) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (start) begin
            r_sr <= '0;
        end else if (w_sample) begin
            r_sr <= w_srShift;
        end
    end

    // A word completing alongside rd_ack replaces the one being acknowledged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_datOut  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done && (!r_valid || rd_ack)) begin
                r_datOut <= w_srShift;
                r_valid  <= 1'b1;
            end else if (rd_ack) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign DatOut  = r_datOut;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign busy    = (r_state == RECV);

endmodule
